// File: rtl/perf_counter_bank.sv
// perf_counter_bank
//
// Memory-mapped bank of event counters. Each channel counts single-cycle pulses
// on its event_inc bit; software reads or writes the counts over a word-addressed
// bus that always answers one cycle after the request.
//
// Address map (byte offsets, address[1:0] ignored):
//   0x00 + 4*i : counter i (i < NUM_CNT), zero-extended to 32 bits
//   0xF8       : sticky overflow flags, write-1-to-clear
//   0xFC       : control {29'b0, clr_on_read, clear_all (write-only), freeze}
//   other      : reads return 0, writes are dropped
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   event_inc  per-channel increment pulses
//   read       bus read request
//   write      bus write request (wins over read when both are high)
//   address    byte address
//   wdata      write data
//   rdata      read data, valid while resp is high, otherwise 0
//   resp       one-cycle acknowledge for each accepted request
module perf_counter_bank #(
  parameter int unsigned NUM_CNT   = 12,
  parameter int unsigned CNT_WIDTH = 32,
  parameter bit          SATURATE  = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_CNT-1:0] event_inc,
  input  logic               read,
  input  logic               write,
  input  logic [7:0]         address,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata,
  output logic               resp
);

  typedef logic [CNT_WIDTH-1:0] cnt_t;

  localparam cnt_t       CntMax  = {CNT_WIDTH{1'b1}};
  localparam cnt_t       CntOne  = cnt_t'(1);
  localparam logic [5:0] OvfIdx  = 6'd62;
  localparam logic [5:0] CtrlIdx = 6'd63;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  cnt_t               cnt_q [NUM_CNT];
  cnt_t               cnt_d [NUM_CNT];
  logic [NUM_CNT-1:0] ovf_q, ovf_d;
  logic               freeze_q, freeze_d;
  logic               clr_on_read_q, clr_on_read_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               resp_q, resp_d;

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic [5:0]         word_idx;
  logic               unused_addr_lsb;
  logic               wr_en;
  logic               rd_en;
  logic               ovf_sel;
  logic               ctrl_sel;
  logic [NUM_CNT-1:0] cnt_hit;

  assign word_idx        = address[7:2];
  assign unused_addr_lsb = ^address[1:0];

  // A simultaneous read is swallowed by the write: no data, no clear-on-read.
  assign wr_en    = write;
  assign rd_en    = read & ~write;
  assign ovf_sel  = (word_idx == OvfIdx);
  assign ctrl_sel = (word_idx == CtrlIdx);

  always_comb begin
    cnt_hit = '0;
    for (int i = 0; i < NUM_CNT; i++) begin
      cnt_hit[i] = (word_idx == 6'(i));
    end
  end

  // ---------------------------------------------------------------------------
  // Per-channel qualifiers
  // ---------------------------------------------------------------------------
  logic               clear_all;
  logic [NUM_CNT-1:0] inc_vec;
  logic [NUM_CNT-1:0] cor_vec;
  logic [NUM_CNT-1:0] cnt_wr_vec;
  logic [NUM_CNT-1:0] ovf_w1c;
  logic [NUM_CNT-1:0] ovf_set;

  assign clear_all  = wr_en & ctrl_sel & wdata[1];
  assign inc_vec    = event_inc & {NUM_CNT{~freeze_q}};
  assign cor_vec    = cnt_hit & {NUM_CNT{rd_en & clr_on_read_q}};
  assign cnt_wr_vec = cnt_hit & {NUM_CNT{wr_en}};
  assign ovf_w1c    = (wr_en & ovf_sel) ? wdata[NUM_CNT-1:0] : '0;

  // ---------------------------------------------------------------------------
  // Counter next state
  // Priority: clear_all > bus write (event dropped) > clear-on-read (event
  // survives as a count of 1) > plain increment.
  // ---------------------------------------------------------------------------
  always_comb begin
    ovf_set = '0;
    for (int i = 0; i < NUM_CNT; i++) begin
      cnt_d[i] = cnt_q[i];
      if (clear_all) begin
        cnt_d[i] = '0;
      end else if (cnt_wr_vec[i]) begin
        cnt_d[i] = wdata[CNT_WIDTH-1:0];
      end else if (cor_vec[i]) begin
        cnt_d[i] = inc_vec[i] ? CntOne : '0;
      end else if (inc_vec[i]) begin
        if (cnt_q[i] == CntMax) begin
          ovf_set[i] = 1'b1;
          cnt_d[i]   = SATURATE ? CntMax : '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CntOne;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Overflow flags and control register
  // ---------------------------------------------------------------------------
  always_comb begin
    // A new overflow beats a same-cycle write-1-to-clear.
    ovf_d = clear_all ? '0 : ((ovf_q & ~ovf_w1c) | ovf_set);

    freeze_d      = freeze_q;
    clr_on_read_d = clr_on_read_q;
    if (wr_en && ctrl_sel) begin
      freeze_d      = wdata[0];
      clr_on_read_d = wdata[2];
    end
  end

  // ---------------------------------------------------------------------------
  // Bus response: sampled from pre-update state, presented the next cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    rdata_d = '0;
    resp_d  = read | write;
    if (rd_en) begin
      if (ctrl_sel) begin
        rdata_d = {29'b0, clr_on_read_q, 1'b0, freeze_q};
      end else if (ovf_sel) begin
        rdata_d = 32'(ovf_q);
      end else begin
        for (int i = 0; i < NUM_CNT; i++) begin
          if (cnt_hit[i]) begin
            rdata_d = 32'(cnt_q[i]);
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q         <= '{default: '0};
      ovf_q         <= '0;
      freeze_q      <= 1'b0;
      clr_on_read_q <= 1'b0;
      rdata_q       <= '0;
      resp_q        <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      ovf_q         <= ovf_d;
      freeze_q      <= freeze_d;
      clr_on_read_q <= clr_on_read_d;
      rdata_q       <= rdata_d;
      resp_q        <= resp_d;
    end
  end

  assign rdata = rdata_q;
  assign resp  = resp_q;

endmodule
